btn_debounce: RTL and testbench
===============================

// Module: btn_debounce
// PURPOSE
//   Input-conditioning stage between the Basys3 push-button pins and top_DH game logic.
//   Synchronises N_BTN asynchronous raw buttons into the 65 MHz game clock domain.
//   Debounces each button with an independent stability counter.
//   Outputs a clean level plus one-cycle press/release pulses per button.
//   Game logic (trigger, aim, start) consumes only these debounced signals.
// PARAMETERS
//   N_BTN          5        number of independent button channels
//   STABLE_CYCLES  650_000  cycles a synced input must differ from btn_level before accepted (10 ms @ 65 MHz); >= 1
// PORTS
//   clk          in   1      game clock (clk65MHz); all logic on rising edge
//   rst_n        in   1      synchronous reset, active low
//   btn_raw      in   N_BTN  raw asynchronous button inputs, active high
//   btn_level    out  N_BTN  debounced button state, active high
//   btn_press    out  N_BTN  1-cycle pulse on debounced 0->1 transition
//   btn_release  out  N_BTN  1-cycle pulse on debounced 1->0 transition
// BEHAVIOUR
//   Reset (rst_n=0 sampled on a clk edge):
//   - sync flops, counters, btn_level, btn_press and btn_release all go to 0.
//   - Counter width: $clog2(STABLE_CYCLES+1).
//   Per channel i (channels fully independent, no shared state):
//   - Synchroniser: 2-flop chain; s1 <= btn_raw[i], s2 <= s1.
//   - Decision each edge, using pre-edge s2, btn_level[i] and cnt:
//     - s2 == btn_level[i]: cnt <= 0 (any glitch restarts the count).
//     - s2 != btn_level[i] && cnt != STABLE_CYCLES-1: cnt <= cnt+1.
//     - s2 != btn_level[i] && cnt == STABLE_CYCLES-1: btn_level[i] <= s2; cnt <= 0;
//       btn_press[i] <= s2; btn_release[i] <= ~s2.
//   - btn_press/btn_release are 0 on every edge not taking the accept branch.
//   - Pulses are therefore exactly 1 cycle wide and coincide with the btn_level edge.
//   - No press and release in the same cycle on the same channel.
//   Latency:
//   - Raw change first sampled on edge 1 and then held stable: btn_level changes
//     on edge STABLE_CYCLES+2, together with the pulse.
//   Counter:
//   - cnt never exceeds STABLE_CYCLES-1; no wrap-around possible.
//   Boundary conditions:
//   - Bounce: any return of s2 to btn_level before acceptance discards progress.
//   - Button held through reset: after reset release, btn_level=0; the held button is
//     reported as a fresh press after STABLE_CYCLES+2 edges (s-chain refills from 0).
//   - Reset mid-count: count is lost; no pulse is emitted for that transition.
//   - Simultaneous changes on several channels yield simultaneous pulses on the same edge.
// TESTING  (bench uses STABLE_CYCLES=4, N_BTN=5)
//   1. Clean press: btn_raw[0] 0->1 before edge 1, held
//      -> btn_level[0]=1 and btn_press[0]=1 at edge 6; btn_press[0]=0 at edge 7.
//   2. Bounce: btn_raw[1] high for 3 cycles, low 1 cycle, high again held
//      -> no change until 6 edges after the final rise; exactly one press pulse.
//   3. Release: from debounced high, btn_raw[0] -> 0 held
//      -> btn_level[0]=0 with btn_release[0]=1 for one cycle, 6 edges later.
//   4. Parallel: btn_raw[4:2] all rise on the same cycle
//      -> btn_press[4:2]=3'b111 on the same edge; other bits stay 0.
//   5. Reset mid-count: btn_raw[3] rises, rst_n=0 at edge 4, released at edge 5, raw held
//      -> no pulse before reset; outputs 0 after reset; press 6 edges after reset release.
//   6. Glitch: 1-cycle high pulse on btn_raw[2]
//      -> btn_level, btn_press and btn_release stay 0 throughout.

Source files
------------

// File: rtl/btn_debounce.sv
// btn_debounce
//   Conditions raw push-button inputs for the game logic. Each channel is brought into the
//   clk domain through a 2-flop synchroniser. A new level is accepted only after the
//   synchronised input has differed from the current debounced level for STABLE_CYCLES
//   consecutive cycles. Accepting a new level also produces a one-cycle press or release
//   pulse, and that pulse lines up with the level edge.
//
// Ports
//   clk          game clock, all logic on the rising edge
//   rst_n        synchronous reset, active low
//   btn_raw      raw asynchronous button inputs, active high
//   btn_level    debounced button state, active high
//   btn_press    one-cycle pulse on a debounced 0->1 transition
//   btn_release  one-cycle pulse on a debounced 1->0 transition

module btn_debounce #(
   parameter int unsigned N_BTN         = 5,
   parameter int unsigned STABLE_CYCLES = 650_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release
);

   localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

   logic [N_BTN-1:0] s1_q, s2_q;
   logic [N_BTN-1:0] level_q, level_d;
   logic [N_BTN-1:0] press_q, press_d;
   logic [N_BTN-1:0] release_q, release_d;
   logic [CntW-1:0]  cnt_q [N_BTN];
   logic [CntW-1:0]  cnt_d [N_BTN];

   // The counter only advances while the synced input disagrees with the debounced level;
   // any agreement clears it, so a bounce throws away all progress.
   always_comb begin
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
      for (int i = 0; i < N_BTN; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != level_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               level_d[i]   = s2_q[i];
               press_d[i]   = s2_q[i];
               release_d[i] = ~s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CntW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q      <= '0;
         s2_q      <= '0;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q      <= btn_raw;
         s2_q      <= s1_q;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         for (int i = 0; i < N_BTN; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce
//   Directed bench for btn_debounce with STABLE_CYCLES=4 and N_BTN=5. Inputs are driven 1 ns
//   after a rising edge, and outputs are sampled at that same point. "Edge e" means the e-th
//   rising edge after the stimulus for a scenario was first applied.

module tb_btn_debounce;

   localparam int unsigned NBtn   = 5;
   localparam int unsigned Stable = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NBtn-1:0] btn_raw;
   logic [NBtn-1:0] btn_level;
   logic [NBtn-1:0] btn_press;
   logic [NBtn-1:0] btn_release;

   int n_checks = 0;
   int n_errors = 0;

   btn_debounce #(
      .N_BTN        (NBtn),
      .STABLE_CYCLES(Stable)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", tag, got[NBtn-1:0], exp[NBtn-1:0]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance one edge, then compare all three outputs.
   task automatic step_check(input string tag, input int e, input logic [NBtn-1:0] lvl,
                             input logic [NBtn-1:0] prs, input logic [NBtn-1:0] rls);
      tick();
      check($sformatf("%s e%0d level", tag, e), 32'(btn_level), 32'(lvl));
      check($sformatf("%s e%0d press", tag, e), 32'(btn_press), 32'(prs));
      check($sformatf("%s e%0d release", tag, e), 32'(btn_release), 32'(rls));
   endtask

   initial begin
      rst_n   = 1'b0;
      btn_raw = '0;
      // Reset with a button already held: outputs must still clear.
      btn_raw = 5'b00001;
      step_check("reset", 1, 5'b0, 5'b0, 5'b0);
      step_check("reset", 2, 5'b0, 5'b0, 5'b0);
      btn_raw = '0;
      step_check("reset", 3, 5'b0, 5'b0, 5'b0);
      rst_n = 1'b1;
      for (int e = 1; e <= 3; e++) step_check("idle", e, 5'b0, 5'b0, 5'b0);

      // 1. Clean press on channel 0: accepted on edge 6.
      btn_raw = 5'b00001;
      for (int e = 1; e <= 7; e++)
         step_check("press0", e, (e >= 6) ? 5'b00001 : 5'b0,
                    (e == 6) ? 5'b00001 : 5'b0, 5'b0);

      // 2. Bounce on channel 1: high 3, low 1, high held; final rise sampled at edge 5.
      for (int e = 1; e <= 12; e++) begin
         btn_raw[1] = (e != 4);
         step_check("bounce1", e, (e >= 10) ? 5'b00011 : 5'b00001,
                    (e == 10) ? 5'b00010 : 5'b0, 5'b0);
      end

      // 3. Release channel 0.
      btn_raw[0] = 1'b0;
      for (int e = 1; e <= 7; e++)
         step_check("release0", e, (e >= 6) ? 5'b00010 : 5'b00011, 5'b0,
                    (e == 6) ? 5'b00001 : 5'b0);

      // 4. Channels 4..2 rise together.
      btn_raw[4:2] = 3'b111;
      for (int e = 1; e <= 7; e++)
         step_check("parallel", e, (e >= 6) ? 5'b11110 : 5'b00010,
                    (e == 6) ? 5'b11100 : 5'b0, 5'b0);

      // Drop channels 4..1 together to return to all-idle.
      btn_raw = '0;
      for (int e = 1; e <= 7; e++)
         step_check("drop", e, (e >= 6) ? 5'b0 : 5'b11110, 5'b0,
                    (e == 6) ? 5'b11110 : 5'b0);

      // 5. Channel 3 rises, reset is sampled at edge 4 only; the chain refills from edge 5.
      btn_raw[3] = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         rst_n = (e != 4);
         step_check("rstmid", e, (e >= 10) ? 5'b01000 : 5'b0,
                    (e == 10) ? 5'b01000 : 5'b0, 5'b0);
      end

      // 6. One-cycle glitch on channel 2 never reaches the outputs.
      for (int e = 1; e <= 10; e++) begin
         btn_raw[2] = (e == 1);
         step_check("glitch2", e, 5'b01000, 5'b0, 5'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
